// File: rtl/inert_intf.sv
`timescale 1ns/1ps
// Inertial sensor front end: SPI master that configures the iNEMO part and,
// on each data-ready INT, reads pitch rate and AZ as four single-byte reads.
module inert_intf #(
   parameter int PWRUP_BITS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld
);

   typedef enum logic [2:0] {
      PWRUP,
      WR_INTCFG,
      WR_GYRO,
      WAIT_INT,
      RD_PL,
      RD_PH,
      RD_AL,
      RD_AH
   } state_t;

   localparam logic [15:0] CMD_INTCFG = 16'h0D02;
   localparam logic [15:0] CMD_GYRO   = 16'h1150;
   localparam logic [15:0] CMD_RD_PL  = 16'hA200;
   localparam logic [15:0] CMD_RD_PH  = 16'hA300;
   localparam logic [15:0] CMD_RD_AL  = 16'hAC00;
   localparam logic [15:0] CMD_RD_AH  = 16'hAD00;
   localparam logic [3:0]  DIV_START  = 4'b1011;

   state_t                  state_q, state_d;
   logic [PWRUP_BITS-1:0]   pwr_cnt_q, pwr_cnt_d;
   logic                    int_meta_q, int_sync_q;
   logic [3:0]              div_q, div_d;
   logic [15:0]             tx_q, tx_d;
   logic [7:0]              rx_q, rx_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic                    porch_q, porch_d;
   logic                    ss_n_q, ss_n_d;
   logic                    done_q, done_d;
   logic [7:0]              pl_q, pl_d;
   logic [7:0]              ph_q, ph_d;
   logic [7:0]              al_q, al_d;
   logic [15:0]             ptch_q, ptch_d;
   logic [15:0]             az_q, az_d;
   logic                    vld_q, vld_d;
   logic                    launch;
   logic [15:0]             launch_cmd;

   always_comb begin
      state_d    = state_q;
      pwr_cnt_d  = pwr_cnt_q;
      div_d      = div_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      bit_cnt_d  = bit_cnt_q;
      porch_d    = porch_q;
      ss_n_d     = ss_n_q;
      done_d     = 1'b0;
      pl_d       = pl_q;
      ph_d       = ph_q;
      al_d       = al_q;
      ptch_d     = ptch_q;
      az_d       = az_q;
      vld_d      = 1'b0;
      launch     = 1'b0;
      launch_cmd = 16'h0000;

      // Serializer: a frame ends on the div==1111 cycle after the 16th sample,
      // leaving SCLK parked high; the first SCLK fall only closes the porch.
      if (!ss_n_q) begin
         if (div_q == 4'b1111 && bit_cnt_q == 5'd16) begin
            ss_n_d = 1'b1;
            done_d = 1'b1;
         end else begin
            div_d = div_q + 4'd1;
            if (div_q == 4'b0111) begin
               rx_d      = {rx_q[6:0], MISO};
               bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (div_q == 4'b1111) begin
               if (porch_q)
                  porch_d = 1'b0;
               else
                  tx_d = {tx_q[14:0], 1'b0};
            end
         end
      end

      case (state_q)
         PWRUP: begin
            if (&pwr_cnt_q) begin
               state_d    = WR_INTCFG;
               launch     = 1'b1;
               launch_cmd = CMD_INTCFG;
            end else begin
               pwr_cnt_d = pwr_cnt_q + {{(PWRUP_BITS-1){1'b0}}, 1'b1};
            end
         end
         WR_INTCFG: begin
            if (done_q) begin
               state_d    = WR_GYRO;
               launch     = 1'b1;
               launch_cmd = CMD_GYRO;
            end
         end
         WR_GYRO: begin
            if (done_q)
               state_d = WAIT_INT;
         end
         WAIT_INT: begin
            if (int_sync_q) begin
               state_d    = RD_PL;
               launch     = 1'b1;
               launch_cmd = CMD_RD_PL;
            end
         end
         RD_PL: begin
            if (done_q) begin
               pl_d       = rx_q;
               state_d    = RD_PH;
               launch     = 1'b1;
               launch_cmd = CMD_RD_PH;
            end
         end
         RD_PH: begin
            if (done_q) begin
               ph_d       = rx_q;
               state_d    = RD_AL;
               launch     = 1'b1;
               launch_cmd = CMD_RD_AL;
            end
         end
         RD_AL: begin
            if (done_q) begin
               al_d       = rx_q;
               state_d    = RD_AH;
               launch     = 1'b1;
               launch_cmd = CMD_RD_AH;
            end
         end
         RD_AH: begin
            // Both words publish together with vld so readers never see a torn pair.
            if (done_q) begin
               ptch_d  = {ph_q, pl_q};
               az_d    = {rx_q, al_q};
               vld_d   = 1'b1;
               state_d = WAIT_INT;
            end
         end
      endcase

      if (launch) begin
         ss_n_d    = 1'b0;
         div_d     = DIV_START;
         tx_d      = launch_cmd;
         bit_cnt_d = 5'd0;
         porch_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= PWRUP;
         pwr_cnt_q  <= '0;
         int_meta_q <= 1'b0;
         int_sync_q <= 1'b0;
         div_q      <= DIV_START;
         tx_q       <= 16'h0000;
         rx_q       <= 8'h00;
         bit_cnt_q  <= 5'd0;
         porch_q    <= 1'b0;
         ss_n_q     <= 1'b1;
         done_q     <= 1'b0;
         pl_q       <= 8'h00;
         ph_q       <= 8'h00;
         al_q       <= 8'h00;
         ptch_q     <= 16'h0000;
         az_q       <= 16'h0000;
         vld_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pwr_cnt_q  <= pwr_cnt_d;
         int_meta_q <= INT;
         int_sync_q <= int_meta_q;
         div_q      <= div_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         bit_cnt_q  <= bit_cnt_d;
         porch_q    <= porch_d;
         ss_n_q     <= ss_n_d;
         done_q     <= done_d;
         pl_q       <= pl_d;
         ph_q       <= ph_d;
         al_q       <= al_d;
         ptch_q     <= ptch_d;
         az_q       <= az_d;
         vld_q      <= vld_d;
      end
   end

   assign SS_n    = ss_n_q;
   assign SCLK    = div_q[3];
   assign MOSI    = tx_q[15];
   assign ptch_rt = ptch_q;
   assign AZ      = az_q;
   assign vld     = vld_q;

endmodule

// File: tb/tb_inert_intf.sv
`timescale 1ns/1ps
// Bench for inert_intf: a mode-3 iNEMO register model answers reads while a
// negedge monitor records frames, SCLK edges, timing and vld events.
module tb_inert_intf;

   localparam int PB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        INT = 1'b0;
   logic        MISO = 1'b0;
   logic        SS_n, SCLK, MOSI, vld;
   logic [15:0] ptch_rt, AZ;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] ptch_rate = 16'h0000;
   logic [15:0] az_val = 16'h0000;

   int          cyc = 0;
   logic        ss_prev = 1'b1, sclk_prev = 1'b1, mosi_prev = 1'b0;
   int          low_len = 0, high_len = 0, edge_cnt = 0, bitn = 0, mosi_bad = 0;
   logic [15:0] mosi_sr = 16'h0000;
   logic [7:0]  mresp = 8'h00;

   logic [15:0] frame_q[$];
   int          len_q[$];
   int          edge_q[$];
   int          gap_q[$];
   int          fall_q[$];
   int          vld_cyc_q[$];
   logic [15:0] vld_pt_q[$];
   logic [15:0] vld_az_q[$];

   always #5 clk = ~clk;

   inert_intf #(.PWRUP_BITS(PB)) dut (
      .clk(clk), .rst_n(rst_n), .INT(INT), .MISO(MISO),
      .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
   );

   // Sensor model plus frame monitor, all sampled mid-cycle on the falling clk.
   always @(negedge clk) begin
      cyc++;
      if (SS_n === 1'b0) begin
         if (ss_prev) begin
            gap_q.push_back(high_len);
            fall_q.push_back(cyc);
            low_len = 0;
            edge_cnt = 0;
            bitn = 0;
            high_len = 0;
         end
         low_len++;
         if (SCLK !== sclk_prev) edge_cnt++;
         if (!ss_prev && MOSI !== mosi_prev && !(sclk_prev && !SCLK)) mosi_bad++;
         if (SCLK && !sclk_prev) begin
            mosi_sr = {mosi_sr[14:0], MOSI};
            bitn++;
            if (bitn == 8) begin
               case (mosi_sr[6:0])
                  7'h22:   mresp = ptch_rate[7:0];
                  7'h23:   mresp = ptch_rate[15:8];
                  7'h2C:   mresp = az_val[7:0];
                  7'h2D:   mresp = az_val[15:8];
                  default: mresp = 8'h00;
               endcase
            end
         end
         if (!SCLK && sclk_prev && bitn >= 8 && bitn < 16) begin
            MISO = mresp[7];
            mresp = {mresp[6:0], 1'b0};
         end
      end else begin
         if (!ss_prev) begin
            frame_q.push_back(mosi_sr);
            len_q.push_back(low_len);
            edge_q.push_back(edge_cnt);
         end
         high_len++;
         MISO = 1'b0;
      end
      if (vld === 1'b1) begin
         vld_cyc_q.push_back(cyc);
         vld_pt_q.push_back(ptch_rt);
         vld_az_q.push_back(AZ);
      end
      ss_prev = SS_n;
      sclk_prev = SCLK;
      mosi_prev = MOSI;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_frames(input int target, input int limit, output bit ok);
      int i = 0;
      while (frame_q.size() < target && i < limit) begin
         tick(1);
         i++;
      end
      ok = (frame_q.size() >= target);
   endtask

   task automatic wait_vlds(input int target, input int limit, output bit ok);
      int i = 0;
      while (vld_cyc_q.size() < target && i < limit) begin
         tick(1);
         i++;
      end
      ok = (vld_cyc_q.size() >= target);
   endtask

   task automatic pulse_int(output int t0);
      INT = 1'b1;
      t0 = cyc;
      tick(4);
      INT = 1'b0;
   endtask

   task automatic test_reset;
      int lows = 0;
      rst_n = 1'b0;
      tick(3);
      tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL rst_ss_n: got %b expected 1", SS_n); end
      tests++; if (SCLK !== 1'b1) begin fails++; $display("FAIL rst_sclk: got %b expected 1", SCLK); end
      tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b expected 0", MOSI); end
      tests++; if (ptch_rt !== 16'h0000) begin fails++; $display("FAIL rst_ptch: got %h expected 0000", ptch_rt); end
      tests++; if (AZ !== 16'h0000) begin fails++; $display("FAIL rst_az: got %h expected 0000", AZ); end
      tests++; if (vld !== 1'b0) begin fails++; $display("FAIL rst_vld: got %b expected 0", vld); end
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         if (SS_n !== 1'b1) lows++;
      end
      tests++; if (lows !== 0) begin fails++; $display("FAIL pwrup_hold: SS_n low in %0d samples, expected 0", lows); end
      tick(1);
      tests++; if (SS_n !== 1'b0) begin fails++; $display("FAIL pwrup_end: SS_n got %b expected 0 after 16 cycles", SS_n); end
   endtask

   task automatic test_init_frames;
      int fb = frame_q.size() - ((SS_n === 1'b0) ? 0 : 1);
      int gb = gap_q.size() - 1;
      bit ok;
      wait_frames(fb + 2, 700, ok);
      tests++; if (!ok) begin fails++; $display("FAIL init_timeout: got %0d frames expected %0d", frame_q.size(), fb + 2); end
      if (ok) begin
         tests++; if (frame_q[fb] !== 16'h0D02) begin fails++; $display("FAIL init_frame0: got %h expected 0d02", frame_q[fb]); end
         tests++; if (frame_q[fb+1] !== 16'h1150) begin fails++; $display("FAIL init_frame1: got %h expected 1150", frame_q[fb+1]); end
         for (int i = 0; i < 2; i++) begin
            tests++; if (len_q[fb+i] !== 261) begin fails++; $display("FAIL init_len%0d: got %0d expected 261", i, len_q[fb+i]); end
            tests++; if (edge_q[fb+i] !== 32) begin fails++; $display("FAIL init_edges%0d: got %0d expected 32", i, edge_q[fb+i]); end
         end
         tests++; if (gap_q[gb+1] !== 1) begin fails++; $display("FAIL init_gap: got %0d expected 1", gap_q[gb+1]); end
      end
   endtask

   task automatic test_read_group;
      int fb, vb, fallb, t0;
      bit ok;
      logic [15:0] exp_f [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
      ptch_rate = 16'h1234;
      az_val = 16'hFFA0;
      tick(5);
      fb = frame_q.size();
      vb = vld_cyc_q.size();
      fallb = fall_q.size();
      pulse_int(t0);
      wait_vlds(vb + 1, 1200, ok);
      tick(20);
      tests++; if (!ok) begin fails++; $display("FAIL rd_timeout: got %0d vld expected %0d", vld_cyc_q.size(), vb + 1); end
      if (ok) begin
         tests++; if (fall_q[fallb] - t0 !== 3) begin fails++; $display("FAIL rd_int_to_ss: got %0d expected 3", fall_q[fallb] - t0); end
         for (int i = 0; i < 4; i++) begin
            tests++; if (frame_q[fb+i] !== exp_f[i]) begin fails++; $display("FAIL rd_frame%0d: got %h expected %h", i, frame_q[fb+i], exp_f[i]); end
            tests++; if (len_q[fb+i] !== 261) begin fails++; $display("FAIL rd_len%0d: got %0d expected 261", i, len_q[fb+i]); end
         end
         tests++; if (vld_cyc_q[vb] - t0 !== 1051) begin fails++; $display("FAIL rd_latency: got %0d expected 1051", vld_cyc_q[vb] - t0); end
         tests++; if (vld_pt_q[vb] !== 16'h1234) begin fails++; $display("FAIL rd_ptch: got %h expected 1234", vld_pt_q[vb]); end
         tests++; if (vld_az_q[vb] !== 16'hFFA0) begin fails++; $display("FAIL rd_az: got %h expected ffa0", vld_az_q[vb]); end
      end
      tests++; if (vld_cyc_q.size() !== vb + 1) begin fails++; $display("FAIL rd_vld_count: got %0d expected %0d", vld_cyc_q.size(), vb + 1); end
      tests++; if (ptch_rt !== 16'h1234 || AZ !== 16'hFFA0) begin fails++; $display("FAIL rd_hold: got %h/%h expected 1234/ffa0", ptch_rt, AZ); end
   endtask

   task automatic test_stability;
      int fb, vb, t0, early = 0, i = 0;
      bit ok;
      ptch_rate = 16'h5678;
      az_val = 16'h0BCD;
      tick(5);
      fb = frame_q.size();
      vb = vld_cyc_q.size();
      pulse_int(t0);
      wait_frames(fb + 2, 700, ok);
      tests++; if (!ok) begin fails++; $display("FAIL stab_frames_timeout: got %0d expected %0d", frame_q.size(), fb + 2); end
      ptch_rate = 16'h9ABC;
      az_val = 16'h1357;
      while (vld_cyc_q.size() == vb && i < 700) begin
         if (ptch_rt !== 16'h1234 || AZ !== 16'hFFA0) early++;
         tick(1);
         i++;
      end
      tests++; if (vld_cyc_q.size() !== vb + 1) begin fails++; $display("FAIL stab_vld_timeout: got %0d expected %0d", vld_cyc_q.size(), vb + 1); end
      tests++; if (early !== 0) begin fails++; $display("FAIL stab_early_update: changed in %0d samples expected 0", early); end
      if (vld_cyc_q.size() > vb) begin
         tests++; if (vld_pt_q[vb] !== 16'h5678) begin fails++; $display("FAIL stab_ptch: got %h expected 5678", vld_pt_q[vb]); end
         tests++; if (vld_az_q[vb] !== 16'h1357) begin fails++; $display("FAIL stab_az: got %h expected 1357", vld_az_q[vb]); end
      end
   endtask

   task automatic test_back_to_back;
      int fb, vb;
      bit ok1, ok2;
      ptch_rate = 16'h0F0F;
      az_val = 16'h8001;
      tick(5);
      fb = frame_q.size();
      vb = vld_cyc_q.size();
      INT = 1'b1;
      wait_vlds(vb + 2, 2400, ok1);
      INT = 1'b0;
      wait_vlds(vb + 3, 1200, ok2);
      tick(1200);
      tests++; if (!(ok1 && ok2)) begin fails++; $display("FAIL b2b_timeout: got %0d vld expected %0d", vld_cyc_q.size(), vb + 3); end
      tests++; if (vld_cyc_q.size() !== vb + 3) begin fails++; $display("FAIL b2b_vld_count: got %0d expected %0d", vld_cyc_q.size(), vb + 3); end
      tests++; if (frame_q.size() !== fb + 12) begin fails++; $display("FAIL b2b_frames: got %0d expected %0d", frame_q.size(), fb + 12); end
      if (ok1 && ok2) begin
         // vld-to-vld: one WAIT_INT cycle plus four 262-cycle frames.
         for (int g = 1; g < 3; g++) begin
            tests++; if (vld_cyc_q[vb+g] - vld_cyc_q[vb+g-1] !== 1049) begin fails++; $display("FAIL b2b_period%0d: got %0d expected 1049", g, vld_cyc_q[vb+g] - vld_cyc_q[vb+g-1]); end
         end
         for (int g = 0; g < 3; g++) begin
            tests++; if (vld_pt_q[vb+g] !== 16'h0F0F || vld_az_q[vb+g] !== 16'h8001) begin fails++; $display("FAIL b2b_data%0d: got %h/%h expected 0f0f/8001", g, vld_pt_q[vb+g], vld_az_q[vb+g]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame;
      int fb, fb2, vb2, t0;
      bit ok;
      ptch_rate = 16'h4242;
      az_val = 16'h2424;
      tick(5);
      fb = frame_q.size();
      pulse_int(t0);
      wait_frames(fb + 1, 700, ok);
      tests++; if (!ok) begin fails++; $display("FAIL mid_timeout: got %0d frames expected %0d", frame_q.size(), fb + 1); end
      tick(121);
      tests++; if (SS_n !== 1'b0) begin fails++; $display("FAIL mid_in_frame: SS_n got %b expected 0", SS_n); end
      tests++; if (ptch_rt !== 16'h0F0F) begin fails++; $display("FAIL mid_pre_ptch: got %h expected 0f0f", ptch_rt); end
      rst_n = 1'b0;
      tick(1);
      tests++; if (SS_n !== 1'b1) begin fails++; $display("FAIL mid_ss_n: got %b expected 1", SS_n); end
      tests++; if (SCLK !== 1'b1) begin fails++; $display("FAIL mid_sclk: got %b expected 1", SCLK); end
      tests++; if (MOSI !== 1'b0) begin fails++; $display("FAIL mid_mosi: got %b expected 0", MOSI); end
      tests++; if (ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin fails++; $display("FAIL mid_outputs: got %h/%h expected 0000/0000", ptch_rt, AZ); end
      tick(2);
      rst_n = 1'b1;
      fb2 = frame_q.size();
      vb2 = vld_cyc_q.size();
      wait_frames(fb2 + 2, 800, ok);
      tests++; if (!ok) begin fails++; $display("FAIL mid_reinit_timeout: got %0d frames expected %0d", frame_q.size(), fb2 + 2); end
      if (ok) begin
         tests++; if (frame_q[fb2] !== 16'h0D02) begin fails++; $display("FAIL mid_reinit0: got %h expected 0d02", frame_q[fb2]); end
         tests++; if (frame_q[fb2+1] !== 16'h1150) begin fails++; $display("FAIL mid_reinit1: got %h expected 1150", frame_q[fb2+1]); end
         tests++; if (len_q[fb2] !== 261) begin fails++; $display("FAIL mid_reinit_len: got %0d expected 261", len_q[fb2]); end
      end
      tests++; if (vld_cyc_q.size() !== vb2) begin fails++; $display("FAIL mid_no_vld: got %0d expected %0d", vld_cyc_q.size(), vb2); end
      tests++; if (ptch_rt !== 16'h0000) begin fails++; $display("FAIL mid_ptch_after: got %h expected 0000", ptch_rt); end
   endtask

   initial begin
      test_reset;
      test_init_frames;
      test_read_group;
      test_stability;
      test_back_to_back;
      test_reset_mid_frame;
      tests++; if (mosi_bad !== 0) begin fails++; $display("FAIL mosi_stable: %0d changes off SCLK fall, expected 0", mosi_bad); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/inert_intf.md
# inert_intf

Inertial-sensor front end for the Segway controller. It is the SPI master that talks to the iNEMO sensor. After power-up it configures the sensor's interrupt and gyro registers. It then waits on the sensor's INT line and, for each INT, reads pitch rate and AZ as four single-byte reads, presenting assembled 16-bit results with a one-cycle valid strobe to the downstream inertial integrator.

## Interface
- PWRUP_BITS, default 16: the power-up wait is 2^PWRUP_BITS clk cycles. Benches may override with a small value.
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- INT  in  1  sensor data-ready. Asynchronous to clk; double-flop synchronized inside the block.
- MISO  in  1  serial data from the sensor
- SS_n  out  1  active-low slave select
- SCLK  out  1  serial clock, clk/16, idles high
- MOSI  out  1  serial data to the sensor
- ptch_rt  out  16  signed pitch rate, {reg 0x23, reg 0x22}
- AZ  out  16  signed Z acceleration, {reg 0x2D, reg 0x2C}
- vld  out  1  one-clk pulse when ptch_rt and AZ have both been updated

## Operation
- **SPI serializer (internal).** 16-bit frames, MSB first, mode 3.
  - Command word format: {R/Wn, addr[6:0], data[7:0]}.
    - Reads use 0x80|addr in the upper byte and 0x00 in the lower byte.
    - The read result is the low byte of the received shift register.
  - 4-bit divider div with SCLK = div[3].
  - On start: SS_n←0, div←4'b1011, the TX shift register is loaded, and MOSI = tx[15].
  - Sample MISO into the RX register when div goes 0111→1000 (SCLK rise).
  - Shift TX when div goes 1111→0000 (SCLK fall). The first fall, which ends the front porch, does not shift.
  - After the 16th sample, when div reaches 1111: SS_n←1, SCLK stays high, and an internal done pulse fires for one cycle.
- **Transaction sequencer FSM** (states and transitions):
  - PWRUP: count 2^PWRUP_BITS clocks → WR_INTCFG.
  - WR_INTCFG: send 0x0D02; on done → WR_GYRO.
  - WR_GYRO: send 0x1150; on done → WAIT_INT.
  - WAIT_INT: on the synchronized INT being high → RD_PL.
  - RD_PL: send 0xA200; on done, capture ptch_rt[7:0] → RD_PH.
  - RD_PH: send 0xA300; on done, capture ptch_rt[15:8] → RD_AL.
  - RD_AL: send 0xAC00; on done, capture AZ[7:0] → RD_AH.
  - RD_AH: send 0xAD00; on done, capture AZ[15:8], pulse vld on the next cycle → WAIT_INT.
- **Holding registers.**
  - Byte captures go to holding registers.
  - ptch_rt and AZ update together, in the cycle vld rises, so consumers never see a half-updated word.
  - Between vld pulses, ptch_rt and AZ hold their values.
- **INT is level-sensitive.**
  - The sensor clears INT when 0x22 is read.
  - An INT that is still or again high on return to WAIT_INT starts a new read group one cycle later.
  - INT activity during RD_* states is ignored (no queueing beyond the level).
- **Reset.** Synchronous reset applies at any point, including mid-frame. On the next clk edge it forces PWRUP and the power-up counter to 0, and drives all outputs to their reset values. No partial frame completes.

## Timing
- Reset values: SS_n=1, SCLK=1, MOSI=0, ptch_rt=0x0000, AZ=0x0000, vld=0. Also FSM=PWRUP and div=4'b1011.
- Frame length: SS_n is low for exactly 261 clk cycles, made up of a 5-cycle front porch plus 16×16.
  - SS_n rises the cycle after the last SCLK high phase ends.
  - Consecutive frames have 1 idle clk with SS_n=1 between them.
- INT synchronizer latency: 2 clk cycles. From INT rise to SS_n fall is 3 clk cycles.
- From INT to vld: 3 + 4×262 clk cycles = 1051 cycles.
- MOSI changes only on SCLK falling edges (div 1111→0000). It is stable across every rising edge.

## Test plan
- **Reset values:** assert rst_n=0 for 3 clk → every output equals its reset value; SS_n stays high during the 2^PWRUP_BITS-cycle wait (PWRUP_BITS=4 → 16 cycles).
- **Init frames:** release reset with PWRUP_BITS=4 → the MOSI bitstream over two frames is 0x0D02 then 0x1150. Each SS_n low interval is 261 cycles, with 32 SCLK edges per frame.
- **Read group against the sensor model:** sensor model with ptch_rate=0x1234 and az=0xFFA0, INT pulsed high → frames 0xA200, 0xA300, 0xAC00, 0xAD00. vld is high for exactly 1 cycle, 1051 cycles after the INT rise, with ptch_rt=0x1234 and AZ=0xFFA0.
- **Output stability between pulses:** change the sensor values after the 2nd frame → ptch_rt and AZ are unchanged until vld. Then they take the mixed-sample values exactly as read.
- **INT held high:** hold INT high continuously → back-to-back read groups with 1 idle cycle between groups and one vld per group.
- **Reset mid-frame:** pull rst_n low at bit 7 of RD_PH → SS_n=1 and SCLK=1 on the next edge. ptch_rt and AZ return to 0. The init writes repeat after the power-up wait.
